// File: rtl/dcdc_pwm_modulator.sv
// Edge-aligned boost PWM with shadowed Q16.16 duty and once-per-period controller sample strobe.
// Define PWM_DEADTIME_EN to drive the complementary low-side gate with dead time.
module dcdc_pwm_modulator #(
    parameter int PERIOD_CYCLES = 1500,
    parameter int CNT_W         = 16,
    parameter int D_MIN         = 0,
    parameter int D_MAX         = 62259,
    parameter int SAMPLE_CNT    = 750,
    parameter int DEADTIME      = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [31:0] i_duty,
    input  logic        i_duty_valid,
    output logic        o_gate_hi,
    output logic        o_gate_lo,
    output logic        o_calc_DV,
    output logic        o_period_start,
    output logic        o_duty_applied,
    output logic        o_clamped
);

    localparam int               PW         = 17 + CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_CNT);
    localparam logic [16:0]      DMIN_Q     = 17'(D_MIN);
    localparam logic [16:0]      DMAX_Q     = 17'(D_MAX);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] on_active;
    logic [CNT_W-1:0] on_pending;
    logic             pend_flag;
    logic             s1_valid;
    logic             s1_clamp;
    logic [16:0]      s1_duty;
    logic             load;
    logic             s2_write;

    always_comb begin
        load     = (cnt == CNT_LAST) && pend_flag;
        // A fresh strobe squashes the command already in S1 so only the latest reaches on_pending.
        s2_write = s1_valid && !i_duty_valid;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt            <= '0;
            on_active      <= '0;
            on_pending     <= '0;
            pend_flag      <= 1'b0;
            s1_valid       <= 1'b0;
            s1_clamp       <= 1'b0;
            s1_duty        <= '0;
            o_gate_hi      <= 1'b0;
            o_calc_DV      <= 1'b0;
            o_period_start <= 1'b0;
            o_duty_applied <= 1'b0;
            o_clamped      <= 1'b0;
        end else begin
            cnt      <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            s1_valid <= i_duty_valid;
            if (i_duty_valid) begin
                if ($signed(i_duty) < D_MIN) begin
                    s1_duty  <= DMIN_Q;
                    s1_clamp <= 1'b1;
                end else if ($signed(i_duty) > D_MAX) begin
                    s1_duty  <= DMAX_Q;
                    s1_clamp <= 1'b1;
                end else begin
                    s1_duty  <= i_duty[16:0];
                    s1_clamp <= 1'b0;
                end
            end

            o_duty_applied <= load;
            o_clamped      <= 1'b0;
            if (load) begin
                on_active <= on_pending;
                pend_flag <= 1'b0;
            end
            // Placed after the load so a coincident S2 write keeps pend_flag set for the next wrap.
            if (s2_write) begin
                on_pending <= CNT_W'((PW'(s1_duty) * PW'(PERIOD_CYCLES)) >> 16);
                pend_flag  <= 1'b1;
                o_clamped  <= s1_clamp;
            end

            o_gate_hi      <= i_en && (cnt < on_active);
            o_calc_DV      <= (cnt == CNT_SAMPLE);
            o_period_start <= (cnt == '0);
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [CNT_W:0] LO_END = (CNT_W+1)'(PERIOD_CYCLES - DEADTIME);

    logic [CNT_W:0] lo_start;

    always_comb lo_start = {1'b0, on_active} + (CNT_W+1)'(DEADTIME);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_gate_lo <= 1'b0;
        end else begin
            o_gate_lo <= i_en && ({1'b0, cnt} >= lo_start) && ({1'b0, cnt} < LO_END);
        end
    end
`else
    assign o_gate_lo = 1'b0;
`endif

    gates_exclusive: assert property (@(posedge i_clk) !(o_gate_hi && o_gate_lo));

endmodule

// File: tb/tb_dcdc_pwm_modulator.sv
// Directed bench for dcdc_pwm_modulator: measures whole PWM periods aligned to o_period_start.
module tb_dcdc_pwm_modulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] duty;
    logic        valid;
    logic        gate_hi, gate_lo, calc_dv, period_start, duty_applied, clamped;

    int checks = 0;
    int errors = 0;

    int m_wait, m_hi, m_lo, m_ovl, m_calc, m_calc_first, m_lo_first, m_ps, m_apl, m_clp;
    int exp_lo, exp_lo_first;

    dcdc_pwm_modulator #(
        .PERIOD_CYCLES(1500),
        .CNT_W(16),
        .D_MIN(0),
        .D_MAX(62259),
        .SAMPLE_CNT(750),
        .DEADTIME(10)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_en(en),
        .i_duty(duty),
        .i_duty_valid(valid),
        .o_gate_hi(gate_hi),
        .o_gate_lo(gate_lo),
        .o_calc_DV(calc_dv),
        .o_period_start(period_start),
        .o_duty_applied(duty_applied),
        .o_clamped(clamped)
    );

    always #5 clk = ~clk;

    // Sample index i sees the counter at value i+1; gates at index i reflect counter value i.
    task automatic measure(input int ia, input logic [31:0] va, input int ib,
                           input logic [31:0] vb, input int en_idx);
        m_wait = 0;
        do begin
            @(negedge clk);
            m_wait++;
        end while (period_start !== 1'b1 && m_wait < 2000);
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL period_sync: o_period_start=%b after %0d clocks, required 1", period_start, m_wait);
            return;
        end
        m_hi = 0; m_lo = 0; m_ovl = 0; m_calc = 0; m_ps = 0; m_apl = 0; m_clp = 0;
        m_calc_first = -1; m_lo_first = -1;
        for (int i = 0; i < 1500; i++) begin
            if (i > 0) @(negedge clk);
            if (gate_hi === 1'b1) m_hi++;
            if (gate_lo === 1'b1) begin
                m_lo++;
                if (m_lo_first < 0) m_lo_first = i;
            end
            if (gate_hi === 1'b1 && gate_lo === 1'b1) m_ovl++;
            if (calc_dv === 1'b1) begin
                m_calc++;
                if (m_calc_first < 0) m_calc_first = i;
            end
            if (period_start === 1'b1) m_ps++;
            if (duty_applied === 1'b1) m_apl++;
            if (clamped === 1'b1) m_clp++;
            valid = (i == ia) || (i == ib);
            if (i == ia) duty = va;
            if (i == ib) duty = vb;
            if (i == en_idx) en = 1'b0;
        end
        valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; valid = 1'b0; duty = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gate_hi, gate_lo, calc_dv, period_start, duty_applied, clamped} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {gate_hi, gate_lo, calc_dv, period_start, duty_applied, clamped});
        end
        rst_n = 1'b1;
        en = 1'b1;
    endtask

    task automatic test_half_duty;
        measure(5, 32'd32768, -1, '0, -1);
        checks++; if (m_wait !== 1) begin errors++; $display("FAIL release_cnt0: period_start after %0d clocks, required 1", m_wait); end
        checks++; if (m_hi !== 0) begin errors++; $display("FAIL half_first_hi: got %0d required 0", m_hi); end
        checks++; if (m_clp !== 0) begin errors++; $display("FAIL half_clamp: got %0d required 0", m_clp); end
        checks++; if (m_apl !== 1) begin errors++; $display("FAIL half_applied: got %0d required 1", m_apl); end
        checks++; if (m_calc !== 1) begin errors++; $display("FAIL calc_count: got %0d required 1", m_calc); end
        checks++; if (m_calc_first !== 750) begin errors++; $display("FAIL calc_pos: got %0d required 750", m_calc_first); end
        checks++; if (m_ps !== 1) begin errors++; $display("FAIL ps_count: got %0d required 1", m_ps); end
        measure(-1, '0, -1, '0, -1);
        checks++; if (m_hi !== 750) begin errors++; $display("FAIL half_hi: got %0d required 750", m_hi); end
        checks++; if (m_apl !== 0) begin errors++; $display("FAIL idle_applied: got %0d required 0", m_apl); end
    endtask

    task automatic test_negative;
        measure(5, 32'hFFFF_FFFB, -1, '0, -1);
        checks++; if (m_hi !== 750) begin errors++; $display("FAIL neg_prev_hi: got %0d required 750", m_hi); end
        checks++; if (m_clp !== 1) begin errors++; $display("FAIL neg_clamp: got %0d required 1", m_clp); end
        checks++; if (m_apl !== 1) begin errors++; $display("FAIL neg_applied: got %0d required 1", m_apl); end
        measure(-1, '0, -1, '0, -1);
        checks++; if (m_hi !== 0) begin errors++; $display("FAIL neg_hi: got %0d required 0", m_hi); end
    endtask

    task automatic test_full_scale;
        measure(5, 32'h0001_0000, -1, '0, -1);
        checks++; if (m_clp !== 1) begin errors++; $display("FAIL max_clamp: got %0d required 1", m_clp); end
        checks++; if (m_apl !== 1) begin errors++; $display("FAIL max_applied: got %0d required 1", m_apl); end
        measure(-1, '0, -1, '0, -1);
        checks++; if (m_hi !== 1424) begin errors++; $display("FAIL max_hi: got %0d required 1424", m_hi); end
    endtask

    task automatic test_mid_period;
        measure(299, 32'd32768, -1, '0, -1);
        checks++; if (m_hi !== 1424) begin errors++; $display("FAIL mid_keep_hi: got %0d required 1424", m_hi); end
        checks++; if (m_apl !== 1) begin errors++; $display("FAIL mid_applied: got %0d required 1", m_apl); end
        measure(-1, '0, -1, '0, -1);
        checks++; if (m_hi !== 750) begin errors++; $display("FAIL mid_new_hi: got %0d required 750", m_hi); end
    endtask

    task automatic test_back_to_back;
        measure(100, 32'hFFFF_FFFF, 101, 32'h0000_4000, -1);
        checks++; if (m_clp !== 0) begin errors++; $display("FAIL b2b_clamp: got %0d required 0", m_clp); end
        checks++; if (m_hi !== 750) begin errors++; $display("FAIL b2b_prev_hi: got %0d required 750", m_hi); end
        measure(-1, '0, -1, '0, -1);
        checks++; if (m_hi !== 375) begin errors++; $display("FAIL b2b_hi: got %0d required 375", m_hi); end
    endtask

    task automatic test_boundary_load;
        // Second command lands in S2 on the very cycle the first one loads.
        measure(100, 32'h0000_8000, 1497, 32'h0000_C000, -1);
        checks++; if (m_hi !== 375) begin errors++; $display("FAIL edge_prev_hi: got %0d required 375", m_hi); end
        checks++; if (m_apl !== 1) begin errors++; $display("FAIL edge_applied1: got %0d required 1", m_apl); end
        measure(-1, '0, -1, '0, -1);
        checks++; if (m_hi !== 750) begin errors++; $display("FAIL edge_old_hi: got %0d required 750", m_hi); end
        checks++; if (m_apl !== 1) begin errors++; $display("FAIL edge_applied2: got %0d required 1", m_apl); end
        measure(-1, '0, -1, '0, -1);
        checks++; if (m_hi !== 1125) begin errors++; $display("FAIL edge_new_hi: got %0d required 1125", m_hi); end
        checks++; if (m_apl !== 0) begin errors++; $display("FAIL edge_applied3: got %0d required 0", m_apl); end
    endtask

    task automatic test_deadtime;
        measure(5, 32'h0000_8000, -1, '0, -1);
        checks++; if (m_hi !== 1125) begin errors++; $display("FAIL dt_prev_hi: got %0d required 1125", m_hi); end
        measure(-1, '0, -1, '0, -1);
`ifdef PWM_DEADTIME_EN
        exp_lo = 730; exp_lo_first = 760;
`else
        exp_lo = 0; exp_lo_first = -1;
`endif
        checks++; if (m_hi !== 750) begin errors++; $display("FAIL dt_hi: got %0d required 750", m_hi); end
        checks++; if (m_lo !== exp_lo) begin errors++; $display("FAIL dt_lo: got %0d required %0d", m_lo, exp_lo); end
        checks++; if (m_lo_first !== exp_lo_first) begin errors++; $display("FAIL dt_lo_start: got %0d required %0d", m_lo_first, exp_lo_first); end
        checks++; if (m_ovl !== 0) begin errors++; $display("FAIL dt_overlap: got %0d required 0", m_ovl); end
        measure(5, 32'h0000_F333, -1, '0, -1);
        checks++; if (m_clp !== 0) begin errors++; $display("FAIL dmax_exact_clamp: got %0d required 0", m_clp); end
        measure(-1, '0, -1, '0, -1);
`ifdef PWM_DEADTIME_EN
        exp_lo = 56;
`else
        exp_lo = 0;
`endif
        checks++; if (m_hi !== 1424) begin errors++; $display("FAIL dt95_hi: got %0d required 1424", m_hi); end
        checks++; if (m_lo !== exp_lo) begin errors++; $display("FAIL dt95_lo: got %0d required %0d", m_lo, exp_lo); end
        checks++; if (m_ovl !== 0) begin errors++; $display("FAIL dt95_overlap: got %0d required 0", m_ovl); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL rstmid_align: period_start=%b required 1", period_start); end
        repeat (899) @(negedge clk);
        checks++; if (gate_hi !== 1'b1) begin errors++; $display("FAIL rstmid_pre_hi: got %b required 1", gate_hi); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({gate_hi, gate_lo, calc_dv, period_start, duty_applied, clamped} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b required 000000",
                     {gate_hi, gate_lo, calc_dv, period_start, duty_applied, clamped});
        end
        @(negedge clk);
        rst_n = 1'b1;
        measure(-1, '0, -1, '0, -1);
        checks++; if (m_wait !== 1) begin errors++; $display("FAIL rstmid_cnt0: period_start after %0d clocks, required 1", m_wait); end
        checks++; if (m_hi !== 0) begin errors++; $display("FAIL rstmid_hi: got %0d required 0", m_hi); end
        checks++; if (m_apl !== 0) begin errors++; $display("FAIL rstmid_applied: got %0d required 0", m_apl); end
        checks++; if (m_calc_first !== 750) begin errors++; $display("FAIL rstmid_calc: got %0d required 750", m_calc_first); end
    endtask

    task automatic test_enable;
        measure(5, 32'h0000_8000, -1, '0, -1);
        checks++; if (m_apl !== 1) begin errors++; $display("FAIL en_applied: got %0d required 1", m_apl); end
        measure(-1, '0, -1, '0, 300);
        checks++; if (m_hi !== 301) begin errors++; $display("FAIL en_drop_hi: got %0d required 301", m_hi); end
        checks++; if (m_lo !== 0) begin errors++; $display("FAIL en_drop_lo: got %0d required 0", m_lo); end
        checks++; if (m_calc !== 1) begin errors++; $display("FAIL en_drop_calc: got %0d required 1", m_calc); end
        measure(-1, '0, -1, '0, -1);
        checks++; if (m_wait !== 1) begin errors++; $display("FAIL en_off_period: period_start after %0d clocks, required 1", m_wait); end
        checks++; if (m_hi !== 0) begin errors++; $display("FAIL en_off_hi: got %0d required 0", m_hi); end
        checks++; if (m_calc_first !== 750) begin errors++; $display("FAIL en_off_calc: got %0d required 750", m_calc_first); end
        checks++; if (m_ps !== 1) begin errors++; $display("FAIL en_off_ps: got %0d required 1", m_ps); end
        en = 1'b1;
    endtask

    initial begin
        test_reset;
        test_half_duty;
        test_negative;
        test_full_scale;
        test_mid_period;
        test_back_to_back;
        test_boundary_load;
        test_deadtime;
        test_reset_mid;
        test_enable;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
